// File: rtl/vec_mem_seq.sv
// ============================================================================
// vec_mem_seq : vld/vst sequencer moving vector elements between memory and
//               one vector register through a 2-stage issue/complete pipeline.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module vec_mem_seq #(
  parameter int NUM_ELEM = 16,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16
) (
  input  logic                        Clk1,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic                        Op,
  input  logic [ADDR_W-1:0]           Base,
  input  logic [2:0]                  VReg,
  input  logic [$clog2(NUM_ELEM)-1:0] Len,
  output logic                        Busy,
  output logic                        Done,
  output logic [ADDR_W-1:0]           Addr,
  output logic                        RD,
  output logic                        WR,
  output logic [DATA_W-1:0]           DataOut,
  input  logic [DATA_W-1:0]           DataIn,
  output logic [2:0]                  vAddr,
  output logic [$clog2(NUM_ELEM)-1:0] vElem,
  output logic                        vRD_s,
  output logic                        vWR_s,
  output logic [DATA_W-1:0]           vDataIn,
  input  logic [DATA_W-1:0]           vDataOut
);

  localparam int EW = $clog2(NUM_ELEM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        vreg_q, vreg_d;
  logic [EW-1:0]     last_q, last_d;
  logic [EW-1:0]     idx_q, idx_d;
  logic              cvalid_q, cvalid_d;
  logic [EW-1:0]     cidx_q, cidx_d;

  logic              issue;
  logic              cmp;

  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      base_q   <= '0;
      vreg_q   <= '0;
      last_q   <= '0;
      idx_q    <= '0;
      cvalid_q <= 1'b0;
      cidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      base_q   <= base_d;
      vreg_q   <= vreg_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      cvalid_q <= cvalid_d;
      cidx_q   <= cidx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    base_d   = base_q;
    vreg_d   = vreg_q;
    last_d   = last_q;
    idx_d    = idx_q;
    // The element issued this cycle completes in the next one.
    cvalid_d = (state_q == S_ISSUE);
    cidx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d    = Op;
          base_d  = Base;
          vreg_d  = VReg;
          // Len=0 wraps to NUM_ELEM-1, i.e. a full vector.
          last_d  = Len - EW'(1);
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (idx_q == last_q) begin
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + EW'(1);
        end
      end
      S_DRAIN: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign issue = (state_q == S_ISSUE);
  assign cmp   = cvalid_q;

  always_comb begin
    Busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    Done    = (state_q == S_FIN);
    RD      = issue & ~op_q;
    vRD_s   = issue &  op_q;
    vWR_s   = cmp   & ~op_q;
    WR      = cmp   &  op_q;
    Addr    = '0;
    DataOut = '0;
    vAddr   = '0;
    vElem   = '0;
    vDataIn = '0;
    // Load drives Addr when issuing, store only when completing.
    if (RD) begin
      Addr = base_q + {{(ADDR_W-EW){1'b0}}, idx_q};
    end else if (WR) begin
      Addr    = base_q + {{(ADDR_W-EW){1'b0}}, cidx_q};
      DataOut = vDataOut;
    end
    if (vRD_s) begin
      vAddr = vreg_q;
      vElem = idx_q;
    end else if (vWR_s) begin
      vAddr   = vreg_q;
      vElem   = cidx_q;
      vDataIn = DataIn;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vec_mem_seq.sv
// ============================================================================
// tb_vec_mem_seq : directed self-checking bench for vec_mem_seq with a
//                  synchronous memory and vector register file model.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_vec_mem_seq;

  logic        Clk1;
  logic        Reset;
  logic        Start;
  logic        Op;
  logic [15:0] Base;
  logic [2:0]  VReg;
  logic [3:0]  Len;
  logic        Busy;
  logic        Done;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic [15:0] DataOut;
  logic [15:0] DataIn;
  logic [2:0]  vAddr;
  logic [3:0]  vElem;
  logic        vRD_s;
  logic        vWR_s;
  logic [15:0] vDataIn;
  logic [15:0] vDataOut;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mem  [0:65535];
  logic [15:0] vreg [0:7][0:15];

  vec_mem_seq #(
    .NUM_ELEM(16),
    .DATA_W  (16),
    .ADDR_W  (16)
  ) u_dut (
    .Clk1    (Clk1),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .Base    (Base),
    .VReg    (VReg),
    .Len     (Len),
    .Busy    (Busy),
    .Done    (Done),
    .Addr    (Addr),
    .RD      (RD),
    .WR      (WR),
    .DataOut (DataOut),
    .DataIn  (DataIn),
    .vAddr   (vAddr),
    .vElem   (vElem),
    .vRD_s   (vRD_s),
    .vWR_s   (vWR_s),
    .vDataIn (vDataIn),
    .vDataOut(vDataOut)
  );

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  // Synchronous-read memory and register file: read data valid next cycle.
  always @(posedge Clk1) begin
    if (RD)    DataIn <= mem[Addr];
    if (WR)    mem[Addr] <= DataOut;
    if (vRD_s) vDataOut <= vreg[vAddr][vElem];
    if (vWR_s) vreg[vAddr][vElem] <= vDataIn;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {26'd0, Busy, Done, RD, WR, vRD_s, vWR_s};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " strobes"}, strobes(), 32'd0);
    check({tag, " addr"}, {Addr, DataOut}, 32'd0);
    check({tag, " vport"}, {9'd0, vAddr, vElem, vDataIn}, 32'd0);
  endtask

  // One transfer, checked cycle by cycle; cycle 0 is the Start cycle.
  task automatic run_xfer(input string name, input bit op, input logic [15:0] base,
                          input logic [2:0] vr, input logic [3:0] len,
                          input logic [15:0] pat, input bit spur, input int rst_at);
    int L;
    int last_c;
    bit iss, cmp, e_rd, e_wr, e_vrd, e_vwr, e_busy, e_done;
    logic [15:0] e_addr, e_dout, e_vdin, a;
    logic [3:0]  e_velem;
    logic [2:0]  e_vaddr;
    L      = (len == 4'd0) ? 16 : int'(len);
    last_c = (rst_at >= 0) ? rst_at : L + 2;
    for (int k = 0; k < L; k++) begin
      a = base + 16'(k);
      if (!op) begin
        mem[a]         <= pat + 16'(k);
        vreg[vr][k]    <= 16'h0000;
      end else begin
        vreg[vr][k]    <= pat + 16'(k);
        mem[a]         <= 16'h0000;
      end
    end
    for (int c = 0; c <= last_c; c++) begin
      @(posedge Clk1); #1;
      Start = (c == 0) || (spur && (c == 5 || c == L + 2));
      if (c == 0) begin
        Op = op; Base = base; VReg = vr; Len = len;
      end else begin
        Op = ~op; Base = 16'h7777; VReg = ~vr; Len = len + 4'd1;
      end
      if (c == rst_at) Reset = 1'b0;
      @(negedge Clk1);
      iss     = (c >= 1) && (c <= L);
      cmp     = (c >= 2) && (c <= L + 1);
      e_rd    = iss && !op;
      e_vrd   = iss && op;
      e_vwr   = cmp && !op;
      e_wr    = cmp && op;
      e_busy  = (c >= 1) && (c <= L + 1);
      e_done  = (c == L + 2);
      e_addr  = e_rd ? base + 16'(c - 1) : (e_wr ? base + 16'(c - 2) : 16'h0000);
      e_velem = e_vrd ? 4'(c - 1) : (e_vwr ? 4'(c - 2) : 4'd0);
      e_vaddr = (e_vrd || e_vwr) ? vr : 3'd0;
      e_dout  = e_wr  ? pat + 16'(c - 2) : 16'h0000;
      e_vdin  = e_vwr ? pat + 16'(c - 2) : 16'h0000;
      check($sformatf("%s c%0d strobes", name, c), strobes(),
            {26'd0, e_busy, e_done, e_rd, e_wr, e_vrd, e_vwr});
      check($sformatf("%s c%0d addr", name, c), {16'd0, Addr}, {16'd0, e_addr});
      check($sformatf("%s c%0d vsel", name, c), {25'd0, vAddr, vElem}, {25'd0, e_vaddr, e_velem});
      check($sformatf("%s c%0d dout", name, c), {16'd0, DataOut}, {16'd0, e_dout});
      check($sformatf("%s c%0d vdin", name, c), {16'd0, vDataIn}, {16'd0, e_vdin});
    end
    Start = 1'b0;
    if (rst_at < 0) begin
      for (int k = 0; k < L; k++) begin
        a = base + 16'(k);
        if (!op) check($sformatf("%s vreg[%0d]", name, k), {16'd0, vreg[vr][k]}, {16'd0, pat + 16'(k)});
        else     check($sformatf("%s mem[%0d]", name, k), {16'd0, mem[a]}, {16'd0, pat + 16'(k)});
      end
    end else begin
      @(posedge Clk1); #1;
      Reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge Clk1);
        check_idle($sformatf("%s post-reset c%0d", name, c));
        @(posedge Clk1); #1;
      end
      // Store completes element k in cycle k+2, so elements 0..rst_at-2 landed.
      for (int k = 0; k < L; k++) begin
        a = base + 16'(k);
        check($sformatf("%s mem[%0d]", name, k), {16'd0, mem[a]},
              {16'd0, (k <= rst_at - 2) ? pat + 16'(k) : 16'h0000});
      end
    end
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    Op    = 1'b0;
    Base  = 16'h0000;
    VReg  = 3'd0;
    Len   = 4'd0;
    DataIn   = 16'h0000;
    vDataOut = 16'h0000;
    repeat (2) @(posedge Clk1);
    @(negedge Clk1);
    check_idle("reset");
    @(posedge Clk1); #1;
    Reset = 1'b1;
    @(negedge Clk1);
    check_idle("idle");

    run_xfer("load_full",  1'b0, 16'h0100, 3'd3, 4'd0, 16'hA000, 1'b0, -1);
    run_xfer("store_full", 1'b1, 16'h2000, 3'd5, 4'd0, 16'h5500, 1'b0, -1);
    run_xfer("wrap",       1'b0, 16'hFFFE, 3'd1, 4'd4, 16'hC000, 1'b0, -1);
    // Spurious Starts at cycles 5 and 18; the next Start lands on cycle 19.
    run_xfer("busy_start", 1'b0, 16'h0400, 3'd2, 4'd0, 16'hB000, 1'b1, -1);
    run_xfer("len1",       1'b0, 16'h0500, 3'd4, 4'd1, 16'hD000, 1'b0, -1);
    run_xfer("rst_store",  1'b1, 16'h3000, 3'd6, 4'd0, 16'h6600, 1'b0, 7);
    run_xfer("after_rst",  1'b1, 16'h3100, 3'd7, 4'd2, 16'h7100, 1'b0, -1);

    @(posedge Clk1); #1;
    @(negedge Clk1);
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
